// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Front-end between the raw active-low board keys and the game logic.
//   For each button the key is synchronised and debounced into a clean level.
//   Single-cycle press, release and auto-repeat events are derived from that level.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   btn_n        raw keys, active-low, asynchronous to clk
//   enable       event enable; low masks press/release/repeat (debounce keeps running)
//   level        debounced pressed state (1 = pressed)
//   press        1-cycle pulse in the cycle level rises
//   release_evt  1-cycle pulse in the cycle level falls
//                (named with a suffix because "release" is a reserved word)
//   repeat_evt   1-cycle auto-repeat pulse while held
//                (named with a suffix because "repeat" is a reserved word)
//   any_press    OR of press bits, same cycle as press
//
// Repeat FSM (one per button)
//   state     | meaning
//   ST_IDLE   | key released or events disabled; no repeat timing
//   ST_DELAY  | held; counting REPEAT_DELAY cycles to the first repeat
//   ST_REPEAT | held; a repeat pulse every REPEAT_RATE cycles
module btn_conditioner #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             enable,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_evt,
  output logic [N_BTN-1:0] repeat_evt,
  output logic             any_press
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_TC  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_TC  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;
  logic             any_press_q, any_press_d;
  logic [N_BTN-1:0] level_rise, level_fall;

  logic [CNT_W-1:0] deb_cnt_q [N_BTN];
  logic [CNT_W-1:0] deb_cnt_d [N_BTN];
  logic [CNT_W-1:0] rpt_cnt_q [N_BTN];
  logic [CNT_W-1:0] rpt_cnt_d [N_BTN];
  rpt_state_e       state_q   [N_BTN];
  rpt_state_e       state_d   [N_BTN];

  // Synchroniser and debounce.
  always_comb begin
    sync1_d = ~btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        // Accept the new level on the terminal count; the counter returns to 0.
        if (deb_cnt_q[i] == DEB_TC) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + ONE;
        end
      end
    end
  end

  // Edge events, registered so they line up with the level change.
  always_comb begin
    level_rise  = level_d & ~level_q;
    level_fall  = ~level_d & level_q;
    press_d     = enable ? level_rise : '0;
    release_d   = enable ? level_fall : '0;
    any_press_d = |press_d;
  end

  // Repeat FSMs. Decisions use level_d so that the FSM leaves IDLE in the same
  // cycle as the press and returns to IDLE in the same cycle as the release.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!enable || !level_d[i]) begin
        state_d[i]   = ST_IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            state_d[i]   = ST_DELAY;
            rpt_cnt_d[i] = '0;
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == RD_TC) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
              state_d[i]   = ST_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + ONE;
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == RR_TC) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + ONE;
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        deb_cnt_q[i] <= '0;
        rpt_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  assign level       = level_q;
  assign press       = press_q;
  assign release_evt = release_q;
  assign repeat_evt  = repeat_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short counts:
// DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic       enable;
  logic [3:0] level, press, release_evt, repeat_evt;
  logic       any_press;

  int n_cmp = 0;
  int n_err = 0;

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .CNT_W(25)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .enable(enable),
    .level(level), .press(press), .release_evt(release_evt),
    .repeat_evt(repeat_evt), .any_press(any_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] btn_n;
    logic       en;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {level, press, release_evt, repeat_evt, any_press};
  endfunction

  function automatic vec_t mk(input logic [3:0] b, input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] r, input logic [3:0] t, input logic a);
    vec_t v;
    v.btn_n = b; v.en = 1'b1; v.lvl = l; v.prs = p; v.rel = r; v.rpt = t; v.any = a;
    return v;
  endfunction

  initial begin
    // Clean press/release on A.
    for (int k = 0; k < 5; k++) vecs.push_back(mk(4'b1110, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(4'b1110, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(4'b1110, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(4'b1111, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    // Bounce on B: low 3, high 1, low 2, high -> never accepted.
    for (int k = 0; k < 3; k++) vecs.push_back(mk(4'b1101, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(4'b1101, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(4'b1111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));

    reset = 1'b1; btn_n = 4'hF; enable = 1'b1;
    tick(); tick(); tick();
    chk("reset_outputs", 32'(outs()), 32'h0);
    reset = 1'b0;
    tick(); tick();
    chk("post_reset_idle", 32'(outs()), 32'h0);

    foreach (vecs[i]) begin
      btn_n  = vecs[i].btn_n;
      enable = vecs[i].en;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rpt, vecs[i].any}));
    end

    // Hold C: repeats at press+10, +13, ...; release so the fall lands on a repeat slot.
    btn_n = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("hold_press_k%0d", k), 32'({level, press, any_press}),
          32'({(k == 6) ? 4'b0100 : 4'b0000, (k == 6) ? 4'b0100 : 4'b0000, k == 6}));
    end
    for (int i = 1; i <= 45; i++) begin
      logic       exp_rpt, exp_rel, exp_lvl;
      tick();
      exp_rpt = (i >= 10) && (i < 37) && (((i - 10) % 3) == 0);
      exp_rel = (i == 37);
      exp_lvl = (i < 37);
      chk($sformatf("hold_i%0d", i), 32'({level, press, release_evt, repeat_evt}),
          32'({1'b0, exp_lvl, 2'b00, 4'h0, 1'b0, exp_rel, 2'b00, 1'b0, exp_rpt, 2'b00}));
      if (i == 31) btn_n = 4'hF;
    end

    // Enable masking on A.
    enable = 1'b0;
    btn_n  = 4'b1110;
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk($sformatf("masked_j%0d", j), 32'({level, press, release_evt, repeat_evt, any_press}),
          32'({(j >= 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}));
    end
    enable = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      chk($sformatf("enable_rise_j%0d", j), 32'({level, press, repeat_evt}),
          32'({4'h1, 4'h0, (j == 11 || j == 14) ? 4'h1 : 4'h0}));
    end
    btn_n = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("enable_release_k%0d", k), 32'({level, release_evt, repeat_evt}),
          32'({(k < 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, (k == 3) ? 4'h1 : 4'h0}));
    end

    // Reset mid-hold on D, then re-acceptance.
    btn_n = 4'b0111;
    for (int k = 1; k <= 9; k++) tick();
    chk("d_held_level", 32'(level), 32'h8);
    reset = 1'b1;
    tick();
    tick();
    chk("reset_mid_hold", 32'(outs()), 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("reaccept_k%0d", k), 32'({level, press, any_press}),
          32'({(k == 6) ? 4'h8 : 4'h0, (k == 6) ? 4'h8 : 4'h0, k == 6}));
    end
    btn_n = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("d_release_k%0d", k), 32'(release_evt), (k == 6) ? 32'h8 : 32'h0);
    end

    // A and D pressed on the same edge.
    btn_n = 4'b0110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("simul_k%0d", k), 32'({level, press, any_press}),
          32'({(k >= 6) ? 4'h9 : 4'h0, (k == 6) ? 4'h9 : 4'h0, k == 6}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input front-end between the raw active-low DE-board keys and the game FSM, ship controller and ammo logic.
- Per button: synchronises, debounces, and produces a clean level plus single-cycle press, release and auto-repeat events.
- Game logic consumes only these events and levels, never raw keys. This gives one-shot starts/restarts and a steady ship step rate while a key is held.

Parameters:
- N_BTN, 4, number of buttons; bit 0=A, 1=B, 2=C, 3=D.
- DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from the press event to the first repeat pulse.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses.
- CNT_W, 25, counter width; 2^CNT_W must exceed the largest of the three count parameters.

Ports:
- clk, in, 1, system clock (50 MHz).
- reset, in, 1, synchronous, active-high.
- btn_n, in, N_BTN, raw keys, active-low (0 = pressed), asynchronous to clk.
- enable, in, 1, event enable; low masks press/release/repeat.
- level, out, N_BTN, debounced pressed state (1 = pressed).
- press, out, N_BTN, 1-cycle pulse on accepted press.
- release, out, N_BTN, 1-cycle pulse on accepted release.
- repeat, out, N_BTN, 1-cycle auto-repeat pulse while held.
- any_press, out, 1, OR of press bits, same cycle as press.

Behaviour:
- Reset: sync flops, level, press, release, repeat, all counters = 0; repeat FSMs = IDLE. The reset value of any_press is 0.
- Sync: btn_n is inverted, then passed through a 2-FF synchroniser, giving s2 (1 = pressed).
- Debounce counter, per bit:
  - s2 == level: counter cleared.
  - s2 != level: counter increments.
  - Counter == DEBOUNCE_CYC-1 while s2 != level: level toggles and the counter clears.
- Latency: level changes on edge 2+DEBOUNCE_CYC, counting the first edge that samples the new raw value as edge 1.
- Bounce: any return to the old value before acceptance clears the counter. No event is produced.
- Events (registered, all-zero when enable=0):
  - press is asserted in the same cycle level rises.
  - release is asserted in the same cycle level falls.
- Repeat FSM per bit: IDLE, DELAY, REPEAT.
  - IDLE -> DELAY when level rises with enable=1; rpt counter = 0.
  - DELAY: counter increments each cycle. At REPEAT_DELAY-1: repeat pulse, counter clears, go to REPEAT.
  - REPEAT: counter increments each cycle. At REPEAT_RATE-1: repeat pulse, counter clears, stay in REPEAT.
  - Any state -> IDLE when level falls or enable=0; counter clears and no repeat pulse that cycle.
  - With the above, the first repeat comes REPEAT_DELAY cycles after press; later repeats come every REPEAT_RATE cycles.
- enable rising while level=1: no press pulse. FSM goes IDLE -> DELAY, counter = 0, so the first repeat comes REPEAT_DELAY cycles later.
- enable=0 does not stop debouncing; level keeps tracking.
- Independence: bits are fully independent. Simultaneous events on several bits are all reported in the same cycle.
- Reset asserted mid-hold: everything clears. A still-held key is re-accepted as a fresh press 2+DEBOUNCE_CYC cycles after reset deasserts.
- Counters never wrap in normal operation, since each clears at its terminal value.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, enable=1 unless stated.
1. Clean press: btn_n[0] 1→0, first sampled at edge 1 → level[0]=1, press[0]=1 and any_press=1 for exactly one cycle at edge 6; other bits stay 0.
2. Bounce: btn_n[1] low 3 cycles, high 1, low 2, then high → level[1], press[1], release[1] remain 0 throughout.
3. Hold: btn_n[2] held low 30 cycles after press → repeat[2] pulses at press+10, +13, +16, +19, ...; each pulse is one cycle wide.
4. Release during REPEAT: btn_n[2] returns high → release[2] pulses 6 edges later; no repeat pulse at or after that edge.
5. Enable masking: key held, enable=0 for 20 cycles → no press/repeat, level stays 1. enable→1 → no press; first repeat 10 cycles later.
6. Reset mid-hold, plus simultaneous press: btn_n[3] held, reset for 2 cycles → all outputs 0. Key still held → press[3] 6 edges after reset deasserts. Pressing A and D on the same edge → press[0] and press[3] assert in the same cycle.
